// File: rtl/bolme_denetleyici_pkg.sv
// bolme_denetleyici_pkg
//   Shared execute-stage definitions for the divide path: integer
//   divide/remainder op codes (the same codes division_unit decodes)
//   and small op-classification helpers.
package bolme_denetleyici_pkg;

    localparam logic [3:0] INT_DIV  = 4'h4;
    localparam logic [3:0] INT_DIVU = 4'h5;
    localparam logic [3:0] INT_REM  = 4'h6;
    localparam logic [3:0] INT_REMU = 4'h7;

    // True for the four op codes this controller is allowed to accept.
    function automatic logic gecerli_islem(input logic [3:0] islem);
        return (islem == INT_DIV)  || (islem == INT_DIVU) ||
               (islem == INT_REM)  || (islem == INT_REMU);
    endfunction

    // True for the signed variants (DIV, REM).
    function automatic logic isaretli(input logic [3:0] islem);
        return (islem == INT_DIV) || (islem == INT_REM);
    endfunction

    // True for quotient-producing ops (DIV, DIVU); false for remainders.
    function automatic logic bolum_mu(input logic [3:0] islem);
        return (islem == INT_DIV) || (islem == INT_DIVU);
    endfunction

endpackage

// File: rtl/bolme_denetleyici_if.sv
// bolme_denetleyici_if
//   Bundles every non-clock signal around bolme_denetleyici: the
//   decode->execute issue channel, the division_unit launch/collect
//   channel and the writeback result channel.
//   master : environment side (upstream pipeline, division_unit, writeback)
//   slave  : controller side
interface bolme_denetleyici_if #(
    parameter int unsigned VERI_BIT   = 32,
    parameter int unsigned YAZMAC_BIT = 5
);
    // issue channel
    logic                  gecerli;
    logic [3:0]            islem;
    logic [VERI_BIT-1:0]   bolunen;
    logic [VERI_BIT-1:0]   bolen;
    logic [YAZMAC_BIT-1:0] hedef_yazmac;
    logic                  durdur;
    // division_unit channel
    logic                  bolum_enable;
    logic [3:0]            bolum_islem;
    logic [VERI_BIT-1:0]   bolum_bolunen;
    logic [VERI_BIT-1:0]   bolum_bolen;
    logic [VERI_BIT-1:0]   bolum_sonuc;
    logic                  bolum_bitti;
    // writeback channel
    logic [VERI_BIT-1:0]   sonuc;
    logic [YAZMAC_BIT-1:0] sonuc_yazmac;
    logic                  sonuc_gecerli;
    logic                  sonuc_hazir;

    modport master (
        output gecerli, islem, bolunen, bolen, hedef_yazmac,
        output bolum_sonuc, bolum_bitti, sonuc_hazir,
        input  durdur, bolum_enable, bolum_islem, bolum_bolunen, bolum_bolen,
        input  sonuc, sonuc_yazmac, sonuc_gecerli
    );

    modport slave (
        input  gecerli, islem, bolunen, bolen, hedef_yazmac,
        input  bolum_sonuc, bolum_bitti, sonuc_hazir,
        output durdur, bolum_enable, bolum_islem, bolum_bolunen, bolum_bolen,
        output sonuc, sonuc_yazmac, sonuc_gecerli
    );

endinterface

// File: rtl/bolme_hizli_yol.sv
// bolme_hizli_yol
//   Combinational RISC-V divide fast-path resolver.
//   islem   : op code (INT_DIV/DIVU/REM/REMU)
//   bolunen : dividend
//   bolen   : divisor
//   isabet  : 1 when the result is fixed by the ISA without dividing
//   sonuc   : that fixed result (don't-care when isabet = 0)
module bolme_hizli_yol
    import bolme_denetleyici_pkg::*;
#(
    parameter int unsigned VERI_BIT = 32
) (
    input  logic [3:0]          islem,
    input  logic [VERI_BIT-1:0] bolunen,
    input  logic [VERI_BIT-1:0] bolen,
    output logic                isabet,
    output logic [VERI_BIT-1:0] sonuc
);

    localparam logic [VERI_BIT-1:0] EN_KUCUK = {1'b1, {(VERI_BIT-1){1'b0}}};
    localparam logic [VERI_BIT-1:0] EKSI_BIR = '1;

    always_comb begin
        isabet = 1'b0;
        sonuc  = '0;
        if (bolen == '0) begin
            // divide by zero: quotient all-ones, remainder is the dividend
            isabet = 1'b1;
            sonuc  = bolum_mu(islem) ? EKSI_BIR : bolunen;
        end else if (isaretli(islem) && (bolunen == EN_KUCUK) && (bolen == EKSI_BIR)) begin
            // signed overflow: quotient wraps to the dividend, remainder 0
            isabet = 1'b1;
            sonuc  = bolum_mu(islem) ? EN_KUCUK : '0;
        end
    end

endmodule

// File: rtl/bolme_denetleyici.sv
// bolme_denetleyici
//   Execute-stage issue/collect controller around division_unit. Accepts
//   one divide/remainder op, resolves divide-by-zero, signed overflow and
//   exact repeats of the last computed op locally, otherwise launches
//   division_unit and waits for bitti. Stalls upstream while busy and
//   holds the result until writeback accepts it.
//   clk_i/rst_i          : clock, async active-low reset
//   gecerli_i..hedef_*_i : issue channel;  durdur_o : upstream stall
//   bolum_*              : division_unit launch/collect channel
//   sonuc_o, hedef_yazmac_o, sonuc_gecerli_o, sonuc_hazir_i : writeback
module bolme_denetleyici
    import bolme_denetleyici_pkg::*;
#(
    parameter int unsigned VERI_BIT   = 32,
    parameter int unsigned YAZMAC_BIT = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  gecerli_i,
    input  logic [3:0]            islem_i,
    input  logic [VERI_BIT-1:0]   bolunen_i,
    input  logic [VERI_BIT-1:0]   bolen_i,
    input  logic [YAZMAC_BIT-1:0] hedef_yazmac_i,
    output logic                  durdur_o,
    output logic                  bolum_enable_o,
    output logic [3:0]            bolum_islem_o,
    output logic [VERI_BIT-1:0]   bolum_bolunen_o,
    output logic [VERI_BIT-1:0]   bolum_bolen_o,
    input  logic [VERI_BIT-1:0]   bolum_sonuc_i,
    input  logic                  bolum_bitti_i,
    output logic [VERI_BIT-1:0]   sonuc_o,
    output logic [YAZMAC_BIT-1:0] hedef_yazmac_o,
    output logic                  sonuc_gecerli_o,
    input  logic                  sonuc_hazir_i
);

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        HESAP = 2'd1,
        SONUC = 2'd2
    } durum_e;

    durum_e durum, durum_sonraki;

    // latched operation, driven straight to division_unit
    logic [3:0]            islem_q;
    logic [VERI_BIT-1:0]   bolunen_q;
    logic [VERI_BIT-1:0]   bolen_q;
    logic [YAZMAC_BIT-1:0] hedef_q;
    logic [VERI_BIT-1:0]   sonuc_q;

    // reuse store: key and result of the last normal-path operation
    logic                  tekrar_gecerli;
    logic [3:0]            tekrar_islem;
    logic [VERI_BIT-1:0]   tekrar_bolunen;
    logic [VERI_BIT-1:0]   tekrar_bolen;
    logic [VERI_BIT-1:0]   tekrar_sonuc;

    logic                  hizli_isabet;
    logic [VERI_BIT-1:0]   hizli_sonuc;
    logic                  kabul;
    logic                  tekrar_isabet;
    logic                  bitti;

    bolme_hizli_yol #(
        .VERI_BIT (VERI_BIT)
    ) u_hizli_yol (
        .islem   (islem_i),
        .bolunen (bolunen_i),
        .bolen   (bolen_i),
        .isabet  (hizli_isabet),
        .sonuc   (hizli_sonuc)
    );

    assign kabul         = (durum == BOS) && gecerli_i && gecerli_islem(islem_i);
    assign tekrar_isabet = tekrar_gecerli && (islem_i == tekrar_islem) &&
                           (bolunen_i == tekrar_bolunen) && (bolen_i == tekrar_bolen);
    assign bitti         = (durum == HESAP) && bolum_bitti_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum <= BOS;
        end else begin
            durum <= durum_sonraki;
        end
    end

    always_comb begin
        durum_sonraki   = durum;
        durdur_o        = 1'b1;
        bolum_enable_o  = 1'b0;
        sonuc_gecerli_o = 1'b0;
        case (durum)
            BOS: begin
                durdur_o = 1'b0;
                if (kabul) begin
                    durum_sonraki = (hizli_isabet || tekrar_isabet) ? SONUC : HESAP;
                end
            end
            HESAP: begin
                bolum_enable_o = 1'b1;
                if (bolum_bitti_i) begin
                    durum_sonraki = SONUC;
                end
            end
            SONUC: begin
                sonuc_gecerli_o = 1'b1;
                if (sonuc_hazir_i) begin
                    durum_sonraki = BOS;
                end
            end
            default: begin
                durum_sonraki = BOS;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            islem_q        <= '0;
            bolunen_q      <= '0;
            bolen_q        <= '0;
            hedef_q        <= '0;
            sonuc_q        <= '0;
            tekrar_gecerli <= 1'b0;
            tekrar_islem   <= '0;
            tekrar_bolunen <= '0;
            tekrar_bolen   <= '0;
            tekrar_sonuc   <= '0;
        end else begin
            if (kabul) begin
                islem_q   <= islem_i;
                bolunen_q <= bolunen_i;
                bolen_q   <= bolen_i;
                hedef_q   <= hedef_yazmac_i;
                // fast-path rules take priority over a reuse hit
                if (hizli_isabet) begin
                    sonuc_q <= hizli_sonuc;
                end else if (tekrar_isabet) begin
                    sonuc_q <= tekrar_sonuc;
                end
            end
            if (bitti) begin
                sonuc_q        <= bolum_sonuc_i;
                tekrar_gecerli <= 1'b1;
                tekrar_islem   <= islem_q;
                tekrar_bolunen <= bolunen_q;
                tekrar_bolen   <= bolen_q;
                tekrar_sonuc   <= bolum_sonuc_i;
            end
        end
    end

    assign bolum_islem_o   = islem_q;
    assign bolum_bolunen_o = bolunen_q;
    assign bolum_bolen_o   = bolen_q;
    assign sonuc_o         = sonuc_q;
    assign hedef_yazmac_o  = hedef_q;

endmodule
